// File: rtl/key_ctrl_multi_if.sv
// Key front-end bundle: raw pins in, debounced level and event pulses out.
interface key_ctrl_multi_if #(
  parameter int N_KEY = 3
);
  logic [N_KEY-1:0] iKey;
  logic [N_KEY-1:0] oLevel;
  logic [N_KEY-1:0] oPress;
  logic [N_KEY-1:0] oRelease;
  logic [N_KEY-1:0] oLong;
  logic [N_KEY-1:0] oRepeat;

  modport master (
    output iKey,
    input  oLevel, oPress, oRelease, oLong, oRepeat
  );

  modport slave (
    input  iKey,
    output oLevel, oPress, oRelease, oLong, oRepeat
  );
endinterface

// File: rtl/key_ctrl_multi.sv
// N-channel push-button front end: synchroniser, debounce, press/release pulses,
// long-press detection and auto-repeat. All outputs are registered.
module key_ctrl_multi #(
  parameter int N_KEY      = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int DEB_CYC    = 1000000,
  parameter int LONG_CYC   = 50000000,
  parameter int REP_CYC    = 10000000,
  parameter int REPEAT_EN  = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  key_ctrl_multi_if.slave  keyIf
);

  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int HMAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int HW   = $clog2(HMAX);

  localparam logic [DW-1:0]    DEB_TC   = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0]    LONG_TC  = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0]    REP_TC   = HW'(REP_CYC - 1);
  localparam logic [N_KEY-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? {N_KEY{1'b1}} : {N_KEY{1'b0}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  logic [N_KEY-1:0] sync1;
  logic [N_KEY-1:0] sync2;
  logic [N_KEY-1:0] keyNorm;
  logic [N_KEY-1:0] level;
  logic [N_KEY-1:0] debDone;
  logic [N_KEY-1:0] pressAcc;
  logic [N_KEY-1:0] releaseAcc;
  logic [N_KEY-1:0] longRaw;
  logic [N_KEY-1:0] repeatRaw;
  logic [N_KEY-1:0] longEv;
  logic [N_KEY-1:0] repeatEv;

  logic [DW-1:0] debCnt     [N_KEY];
  logic [DW-1:0] debCntNxt  [N_KEY];
  logic [HW-1:0] holdCnt    [N_KEY];
  logic [HW-1:0] holdCntNxt [N_KEY];
  logic [1:0]    holdSt     [N_KEY];
  logic [1:0]    holdStNxt  [N_KEY];

  // Debounce counters and accepted press/release edges (level vs. its registered copy).
  always_comb begin
    keyNorm    = sync2 ^ IDLE_PIN;
    debDone    = {N_KEY{1'b0}};
    pressAcc   = level & ~keyIf.oLevel;
    releaseAcc = ~level & keyIf.oLevel;
    for (int i = 0; i < N_KEY; i++) begin
      debCntNxt[i] = {DW{1'b0}};
      if (keyNorm[i] != level[i]) begin
        if (debCnt[i] == DEB_TC) begin
          debDone[i] = 1'b1;
        end else begin
          debCntNxt[i] = debCnt[i] + 1'b1;
        end
      end else begin
        debCntNxt[i] = {DW{1'b0}};
      end
    end
  end

  // Hold FSM per channel; an accepted release overrides any terminal count in the same cycle.
  always_comb begin
    longRaw   = {N_KEY{1'b0}};
    repeatRaw = {N_KEY{1'b0}};
    longEv    = {N_KEY{1'b0}};
    repeatEv  = {N_KEY{1'b0}};
    for (int i = 0; i < N_KEY; i++) begin
      holdStNxt[i]  = holdSt[i];
      holdCntNxt[i] = holdCnt[i];
      case (holdSt[i])
        ST_IDLE: begin
          holdCntNxt[i] = {HW{1'b0}};
          if (pressAcc[i]) begin
            holdStNxt[i] = ST_HOLD;
          end else begin
            holdStNxt[i] = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (holdCnt[i] == LONG_TC) begin
            longRaw[i]    = 1'b1;
            holdCntNxt[i] = {HW{1'b0}};
            holdStNxt[i]  = ST_LONG;
          end else begin
            holdCntNxt[i] = holdCnt[i] + 1'b1;
          end
        end
        ST_LONG: begin
          if (REPEAT_EN != 0) begin
            if (holdCnt[i] == REP_TC) begin
              repeatRaw[i]  = 1'b1;
              holdCntNxt[i] = {HW{1'b0}};
            end else begin
              holdCntNxt[i] = holdCnt[i] + 1'b1;
            end
          end else begin
            holdCntNxt[i] = {HW{1'b0}};
          end
        end
        default: begin
          holdStNxt[i]  = ST_IDLE;
          holdCntNxt[i] = {HW{1'b0}};
        end
      endcase
      if (releaseAcc[i]) begin
        holdStNxt[i]  = ST_IDLE;
        holdCntNxt[i] = {HW{1'b0}};
      end else begin
        longEv[i]   = longRaw[i];
        repeatEv[i] = repeatRaw[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1          <= IDLE_PIN;
      sync2          <= IDLE_PIN;
      level          <= {N_KEY{1'b0}};
      keyIf.oLevel   <= {N_KEY{1'b0}};
      keyIf.oPress   <= {N_KEY{1'b0}};
      keyIf.oRelease <= {N_KEY{1'b0}};
      keyIf.oLong    <= {N_KEY{1'b0}};
      keyIf.oRepeat  <= {N_KEY{1'b0}};
      for (int i = 0; i < N_KEY; i++) begin
        debCnt[i]  <= {DW{1'b0}};
        holdCnt[i] <= {HW{1'b0}};
        holdSt[i]  <= ST_IDLE;
      end
    end else begin
      sync1          <= keyIf.iKey;
      sync2          <= sync1;
      level          <= level ^ debDone;
      keyIf.oLevel   <= level;
      keyIf.oPress   <= pressAcc;
      keyIf.oRelease <= releaseAcc;
      keyIf.oLong    <= longEv;
      keyIf.oRepeat  <= repeatEv;
      for (int i = 0; i < N_KEY; i++) begin
        debCnt[i]  <= debCntNxt[i];
        holdCnt[i] <= holdCntNxt[i];
        holdSt[i]  <= holdStNxt[i];
      end
    end
  end

endmodule
